dma_psdpram_fwd: RTL

//  Segmented simple dual port RAM for DMA engine buffers: SEG_COUNT independent segments, one write port and one read port each.

---
 rtl/dma_psdpram_fwd_if.sv | 42 ++++
 rtl/dma_psdpram_fwd.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dma_psdpram_fwd_if.sv
// Bus bundle for dma_psdpram_fwd: per-segment write command, read command
// and read response channels, flattened as SEG_COUNT-wide vectors.
// master = DMA/client side, slave = the RAM.
interface dma_psdpram_fwd_if #(
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8
);
  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data;
  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_par_inv;
  logic [SEG_COUNT-1:0]                wr_cmd_valid;
  logic [SEG_COUNT-1:0]                wr_cmd_ready;
  logic [SEG_COUNT-1:0]                wr_done;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr;
  logic [SEG_COUNT-1:0]                rd_cmd_valid;
  logic [SEG_COUNT-1:0]                rd_cmd_ready;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data;
  logic [SEG_COUNT-1:0]                rd_resp_err;
  logic [SEG_COUNT-1:0]                rd_resp_valid;
  logic [SEG_COUNT-1:0]                rd_resp_ready;

  modport master (
    output wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_par_inv, wr_cmd_valid,
    input  wr_cmd_ready, wr_done,
    output rd_cmd_addr, rd_cmd_valid,
    input  rd_cmd_ready,
    input  rd_resp_data, rd_resp_err, rd_resp_valid,
    output rd_resp_ready
  );

  modport slave (
    input  wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_par_inv, wr_cmd_valid,
    output wr_cmd_ready, wr_done,
    input  rd_cmd_addr, rd_cmd_valid,
    output rd_cmd_ready,
    output rd_resp_data, rd_resp_err, rd_resp_valid,
    input  rd_resp_ready
  );
endinterface

// File: rtl/dma_psdpram_fwd.sv
// Segmented simple dual-port RAM for DMA buffers. Each segment has one
// write port and one read port, write-first same-cycle forwarding, a
// write-completion pulse and a PIPELINE-deep read pipeline that compacts
// through bubbles and buffers up to PIPELINE responses under backpressure.
// Optional per-byte even parity is enabled by defining DMA_PSDPRAM_FWD_PARITY_EN.
module dma_psdpram_fwd #(
  parameter int SIZE           = 4096,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int PIPELINE       = 2
) (
  input logic               clk,
  input logic               rst,
  dma_psdpram_fwd_if.slave  bus
);
  localparam int INT_ADDR_WIDTH = $clog2(SIZE / (SEG_COUNT * SEG_BE_WIDTH));
  localparam int MEM_WORDS      = 32'd1 << INT_ADDR_WIDTH;

`ifdef DMA_PSDPRAM_FWD_PARITY_EN
  // even parity of every byte of a segment word
  function automatic logic [SEG_BE_WIDTH-1:0] byte_par(input logic [SEG_DATA_WIDTH-1:0] d);
    for (int b = 0; b < SEG_BE_WIDTH; b++) begin
      byte_par[b] = ^d[b*8 +: 8];
    end
  endfunction
`endif

  // Upper address bits (and the parity hook in the plain build) are ignored.
  logic unused_s;
`ifdef DMA_PSDPRAM_FWD_PARITY_EN
  assign unused_s = ^{bus.wr_cmd_addr, bus.rd_cmd_addr};
`else
  assign unused_s = ^{bus.wr_cmd_addr, bus.rd_cmd_addr, bus.wr_cmd_par_inv};
`endif

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    logic [SEG_DATA_WIDTH-1:0] mem_r [MEM_WORDS];
    logic [INT_ADDR_WIDTH-1:0] wr_addr_s;
    logic [INT_ADDR_WIDTH-1:0] rd_addr_s;
    logic [SEG_DATA_WIDTH-1:0] wr_data_s;
    logic [SEG_BE_WIDTH-1:0]   wr_be_s;
    logic [SEG_DATA_WIDTH-1:0] rd_old_s;
    logic [SEG_DATA_WIDTH-1:0] rd_data_s;
    logic                      rd_err_s;
    logic                      wr_accept_s;
    logic                      rd_cmd_ready_s;
    logic                      rd_accept_s;
    logic                      fwd_s;
    logic                      wr_done_r;
    logic [PIPELINE-1:0]       valid_r;
    logic [PIPELINE-1:0]       err_r;
    logic [PIPELINE-1:0]       free_s;
    logic [SEG_DATA_WIDTH-1:0] data_r [PIPELINE];

    assign wr_addr_s      = bus.wr_cmd_addr[n*SEG_ADDR_WIDTH +: INT_ADDR_WIDTH];
    assign rd_addr_s      = bus.rd_cmd_addr[n*SEG_ADDR_WIDTH +: INT_ADDR_WIDTH];
    assign wr_data_s      = bus.wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
    assign wr_be_s        = bus.wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH];
    assign wr_accept_s    = bus.wr_cmd_valid[n] && !rst;
    assign rd_cmd_ready_s = !rst && free_s[0];
    assign rd_accept_s    = bus.rd_cmd_valid[n] && rd_cmd_ready_s;
    assign fwd_s          = wr_accept_s && (wr_addr_s == rd_addr_s);

    assign bus.wr_cmd_ready[n]  = !rst;
    assign bus.rd_cmd_ready[n]  = rd_cmd_ready_s;
    assign bus.wr_done[n]       = wr_done_r;
    assign bus.rd_resp_valid[n] = valid_r[PIPELINE-1];
    assign bus.rd_resp_err[n]   = err_r[PIPELINE-1];
    assign bus.rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = data_r[PIPELINE-1];

    // byte-enabled write into the segment array (contents survive reset)
    always_ff @(posedge clk) begin
      for (int b = 0; b < SEG_BE_WIDTH; b++) begin
        if (wr_accept_s && wr_be_s[b]) begin
          mem_r[wr_addr_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
        end
      end
    end

    // write-first read: bytes being written to the same word this cycle come from the write port
    always_comb begin
      rd_old_s  = mem_r[rd_addr_s];
      rd_data_s = rd_old_s;
      for (int b = 0; b < SEG_BE_WIDTH; b++) begin
        if (fwd_s && wr_be_s[b]) begin
          rd_data_s[b*8 +: 8] = wr_data_s[b*8 +: 8];
        end else begin
          rd_data_s[b*8 +: 8] = rd_old_s[b*8 +: 8];
        end
      end
    end

`ifdef DMA_PSDPRAM_FWD_PARITY_EN
    logic [SEG_BE_WIDTH-1:0] par_mem_r [MEM_WORDS];
    logic [SEG_BE_WIDTH-1:0] wr_par_s;
    logic [SEG_BE_WIDTH-1:0] rd_par_s;

    assign wr_par_s = byte_par(wr_data_s) ^ bus.wr_cmd_par_inv[n*SEG_BE_WIDTH +: SEG_BE_WIDTH];

    // stored parity bits follow the same byte enables as the data
    always_ff @(posedge clk) begin
      for (int b = 0; b < SEG_BE_WIDTH; b++) begin
        if (wr_accept_s && wr_be_s[b]) begin
          par_mem_r[wr_addr_s][b] <= wr_par_s[b];
        end
      end
    end

    // forwarded bytes carry forwarded parity; error is any byte mismatch
    always_comb begin
      rd_par_s = par_mem_r[rd_addr_s];
      for (int b = 0; b < SEG_BE_WIDTH; b++) begin
        if (fwd_s && wr_be_s[b]) begin
          rd_par_s[b] = wr_par_s[b];
        end else begin
          rd_par_s[b] = par_mem_r[rd_addr_s][b];
        end
      end
      rd_err_s = |(byte_par(rd_data_s) ^ rd_par_s);
    end
`else
    assign rd_err_s = 1'b0;
`endif

    // a stage can load when it or any stage after it is empty, or the output is draining
    always_comb begin : p_free
      logic acc;
      acc = bus.rd_resp_ready[n];
      for (int j = PIPELINE - 1; j >= 0; j--) begin
        acc       = acc || !valid_r[j];
        free_s[j] = acc;
      end
    end

    // read pipeline: shift/compact toward the output, stage0 takes accepted reads
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= '0;
        err_r   <= '0;
      end else begin
        for (int j = PIPELINE - 1; j >= 1; j--) begin
          if (free_s[j]) begin
            valid_r[j] <= valid_r[j-1];
            err_r[j]   <= err_r[j-1];
            data_r[j]  <= data_r[j-1];
          end
        end
        if (free_s[0]) begin
          valid_r[0] <= rd_accept_s;
          err_r[0]   <= rd_accept_s && rd_err_s;
          data_r[0]  <= rd_data_s;
        end
      end
    end

    // write-completion pulse, one cycle after acceptance
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_done_r <= 1'b0;
      end else begin
        wr_done_r <= wr_accept_s;
      end
    end
  end
endmodule
